// File: rtl/labft_error_reporter.sv
// labft_error_reporter
// Takes a snapshot of the detector's sticky error vector and hands each set bit
// to the host as one (group, lane) record over a valid/ack handshake. irq stays
// high for the whole episode. When the host clears, a one-cycle interrupt pulse
// goes back to the detector. The block then re-arms once the detector's vector
// has returned to zero.
//
// Optional feature: define LABFT_ERR_COUNT_EN to build the saturating episode
// counter. When the macro is undefined, err_count is tied to zero.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   error      in   detector vector {abcd, e, w, x, y, z}, z in the low lanes
//   rd_ack     in   host accepts the current record
//   clear      in   host ends the episode
//   irq        out  error episode active
//   rd_valid   out  record valid
//   rd_group   out  record group (0=z .. 5=abcd)
//   rd_lane    out  record lane within the group
//   done       out  all records delivered
//   interrupt  out  one-cycle pulse back to the detector
//   err_count  out  saturating episode count
module labft_error_reporter #(
    parameter int unsigned arraySize = 4,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned LANE_W   = ($clog2(arraySize) > 0) ? $clog2(arraySize) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6*arraySize-1:0] error,
    input  logic                   rd_ack,
    input  logic                   clear,
    output logic                   irq,
    output logic                   rd_valid,
    output logic [2:0]             rd_group,
    output logic [LANE_W-1:0]      rd_lane,
    output logic                   done,
    output logic                   interrupt,
    output logic [CNT_W-1:0]       err_count
);

    localparam int unsigned ERR_W = 6 * arraySize;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_READY   = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ERR_W-1:0]   pending;
    logic [ERR_W-1:0]   sel_mask;
    logic [ERR_W-1:0]   remaining;
    logic [ERR_W-1:0]   low_mask;
    logic [2:0]         enc_group;
    logic [LANE_W-1:0]  enc_lane;
    logic               start;

    assign start     = (state == S_IDLE) && (error != '0);
    assign remaining = pending & ~sel_mask;

    // Lowest set bit of pending: iterate downward so the lowest index wins.
    always_comb begin
        enc_group = '0;
        enc_lane  = '0;
        low_mask  = '0;
        for (int i = int'(ERR_W) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                enc_group = 3'(i / int'(arraySize));
                enc_lane  = LANE_W'(i % int'(arraySize));
                low_mask  = ERR_W'(1) << i;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; rd_ack takes priority over clear because clear only matters in DONE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (error != '0) state_next = S_SCAN;
            S_SCAN:    state_next = S_READY;
            S_READY:   if (rd_ack) state_next = (remaining == '0) ? S_DONE : S_SCAN;
            S_DONE:    if (clear) state_next = S_RELEASE;
            S_RELEASE: state_next = S_WAIT;
            S_WAIT:    if (error == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        irq       = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        interrupt = 1'b0;
        case (state)
            S_SCAN:    irq = 1'b1;
            S_READY:   begin irq = 1'b1; rd_valid  = 1'b1; end
            S_DONE:    begin irq = 1'b1; done      = 1'b1; end
            S_RELEASE: begin irq = 1'b1; interrupt = 1'b1; end
            default:   ;
        endcase
    end

    // Snapshot, record registers and retirement of acknowledged bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            sel_mask <= '0;
            rd_group <= '0;
            rd_lane  <= '0;
        end else begin
            if (start) begin
                pending <= error;
            end else if ((state == S_READY) && rd_ack) begin
                pending <= remaining;
            end
            if (state == S_SCAN) begin
                sel_mask <= low_mask;
                rd_group <= enc_group;
                rd_lane  <= enc_lane;
            end
        end
    end

`ifdef LABFT_ERR_COUNT_EN
    // Episode counter, holds at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (start && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: doc/labft_error_reporter.md
# labft_error_reporter

Downstream consumer of `mem_error_detector`. Snapshots its sticky `error` vector, returns the set bits to the host one record at a time (group and lane) over a valid/ack handshake, and raises `irq` for the whole episode. When the host clears, it pulses `interrupt` for one cycle back to the detector, then re-arms once the detector's vector has dropped to zero.

## Interface
- `arraySize`, 4: lanes per error group; `error` is 6*arraySize bits wide.
- `CNT_W`, 8: width of the episode counter.
- `LANE_W`, derived: max(1, $clog2(arraySize)).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `error`  in  6*arraySize  from the detector. Bit layout: {abcd, e, w, x, y, z}, with z in bits [arraySize-1:0].
- `rd_ack`  in  1  host accepts the current record.
- `clear`  in  1  host ends the episode.
- `irq`  out  1  error episode active.
- `rd_valid`  out  1  record valid.
- `rd_group`  out  3  record group: 0=z, 1=y, 2=x, 3=w, 4=e, 5=abcd.
- `rd_lane`  out  LANE_W  record lane within the group.
- `done`  out  1  all records delivered.
- `interrupt`  out  1  one-cycle pulse to the detector's `interrupt` input.
- `err_count`  out  CNT_W  saturating episode count.

## Operation
- Internal registers:
  - `pending`, 6*arraySize bits.
  - Record registers.
  - `err_count`.
  - 3-bit state.
- Reset (async, active-high): all registers and all outputs go to 0, state goes to IDLE.
- Record encoding for bit index b: `rd_group` = b / arraySize, `rd_lane` = b % arraySize.
- Scan order: lowest set bit of `pending` first.
- IDLE:
  - `irq` = 0.
  - If `error` != 0: load `pending` <= `error`, increment `err_count` (saturating at 2^CNT_W-1), go to SCAN.
- SCAN (`irq` = 1):
  - Priority-encode the lowest set bit of `pending`.
  - Register it into `rd_group`/`rd_lane`.
  - Go to READY.
- READY (`irq` = 1, `rd_valid` = 1):
  - Record outputs are stable.
  - On `rd_ack`: clear that bit in `pending`. If the result is 0, go to DONE; otherwise go to SCAN.
- DONE (`irq` = 1, `done` = 1):
  - On `clear`: go to RELEASE.
- RELEASE (`irq` = 1):
  - `interrupt` = 1 for exactly this cycle.
  - Go to WAIT.
- WAIT (`irq` = 0):
  - Stay until `error` == 0, then go to IDLE.
  - This covers the detector holding `error` for one cycle after `interrupt`.
- Boundary rules:
  - Changes on `error` after the snapshot are ignored until IDLE.
  - `rd_ack` outside READY is ignored.
  - `clear` outside DONE is ignored.
  - `rd_ack` and `clear` asserted together in READY: only `rd_ack` is acted on.
  - If all 6*arraySize bits are set, the block delivers 6*arraySize records and then DONE.
  - `err_count` holds at its maximum value; it never wraps.

## Timing
- Error-to-first-record latency:
  - `error` != 0 in IDLE during cycle n.
  - `irq` = 1 in cycle n+1.
  - `rd_valid` = 1 in cycle n+2.
- Record-to-record latency: `rd_ack` in cycle m gives `rd_valid` = 0 in cycle m+1 and the next `rd_valid` = 1 in cycle m+2. Throughput is one record per two cycles minimum.
- DONE:
  - Last `rd_ack` in cycle m gives `done` = 1 from cycle m+1.
  - `done` holds until `clear` is accepted.
- Release: `clear` in cycle d gives `interrupt` = 1 in cycle d+1 only and `irq` = 0 from cycle d+2.
- Re-arm: the block is back in IDLE one cycle after the first WAIT cycle that sees `error` == 0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Configuration
- `LABFT_ERR_COUNT_EN`:
  - Defined: `err_count` is implemented as described above.
  - Undefined: the counter is not instantiated and `err_count` is tied to 0. All other behaviour is identical.

## Test plan
- Single error (arraySize=4, `error`=24'h000010, bit 4): `rd_valid` appears 2 cycles after `error` goes nonzero with `rd_group`=1, `rd_lane`=0. After `rd_ack`, `done` = 1. After `clear`, `interrupt` pulses for one cycle. After `error` returns to 0, the block is in IDLE and `err_count`=1.
- Multiple errors (`error`=24'h800101, bits 0, 8 and 23): records arrive in order (0,0), (2,0), (5,3), each two cycles after the previous `rd_ack`.
- Ignored strobes: `rd_ack` held high from the first cycle of the episode delivers all records at one per two cycles. `clear` asserted during READY is ignored and `done` stays 0.
- Snapshot isolation: `error` changes to 24'hFFFFFF after the snapshot of 24'h000001 → exactly one record is delivered. After `clear`, the block stays in WAIT (`irq` = 0, no new episode) while `error` is still nonzero.
- Saturation: with CNT_W=2 and the macro defined, run five episodes → `err_count` reads 1, 2, 3, 3, 3. With the macro undefined, `err_count`=0 throughout.
- Reset mid-operation: assert `rst` asynchronously while in READY → `irq`, `rd_valid`, `done`, `interrupt` and `err_count` drop to 0 immediately (no clock needed). The block restarts a fresh episode only after `rst` is released and `error` is nonzero.
